// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported memory.
// One transaction in flight; round-robin on simultaneous requests.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              spurious_rsp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_win, dm_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_DM;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The port that did not win last time takes a tie.
    assign if_win = if_req && (!dm_req || (last_q == OWN_DM));
    assign dm_win = dm_req && !if_win;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_gnt       = 1'b0;
        dm_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        dm_rvalid    = 1'b0;
        if_rdata     = '0;
        dm_rdata     = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rst && (if_win || dm_win)) begin
                    if_gnt  = if_win;
                    dm_gnt  = dm_win;
                    owner_d = dm_win;
                    last_d  = dm_win;
                    we_d    = dm_win & dm_we;
                    addr_d  = dm_win ? dm_addr : if_addr;
                    wdata_d = dm_win ? dm_wdata : '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    if (owner_q == OWN_DM) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign spurious_rsp = rst && mem_rvalid && (state_q != WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small memory responder.
// Per-port queues hold expected responses pushed when requests are raised.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy, spurious_rsp;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .spurious_rsp(spurious_rsp)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mm_mem  [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    logic [31:0] if_q [$];
    logic [32:0] dm_q [$];
    int          gnt_log [$];

    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic        exp_we = 1'b0;
    int issue_cnt = 0, busy_cnt = 0, last_issue = 0, last_busy = 0;

    int gnt_wait = 0, rsp_wait = 0;
    bit inj = 1'b0;
    int mm_ph = 0, mm_cnt = 0;
    logic [31:0] mm_a = '0;
    logic        mm_w = 1'b0;

    // Memory responder: grant after gnt_wait cycles, answer rsp_wait later.
    initial begin : mem_model
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                mem_gnt    = 1'($urandom_range(0, 1));
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                mm_ph      = 0;
                mm_cnt     = 0;
            end else begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
                if (inj) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hBAD0_BAD0;
                    inj        = 1'b0;
                end else if (mm_ph == 0) begin
                    if (mem_req) begin
                        if (mm_cnt >= gnt_wait) begin
                            mem_gnt = 1'b1;
                            mm_a    = mem_addr;
                            mm_w    = mem_we;
                            if (mm_w) mm_mem[mm_a] = mem_wdata;
                            mm_ph   = 1;
                            mm_cnt  = 0;
                        end else begin
                            mm_cnt++;
                        end
                    end
                end else begin
                    if (mm_cnt >= rsp_wait) begin
                        mem_rvalid = 1'b1;
                        if (mm_w) mem_rdata = '0;
                        else mem_rdata = mm_mem.exists(mm_a) ? mm_mem[mm_a] : ~mm_a;
                        mm_ph  = 0;
                        mm_cnt = 0;
                    end else begin
                        mm_cnt++;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic [32:0] e;
        logic [31:0] ei;
        forever begin
            @(negedge clk);
            if (busy) check("gnt_in_busy", {62'b0, if_gnt, dm_gnt}, 64'd0);
            else check("mem_req_idle", {63'b0, mem_req}, 64'd0);
            if (if_gnt) begin
                exp_addr = if_addr; exp_we = 1'b0; exp_wdata = '0;
                gnt_log.push_back(0);
                issue_cnt = 0; busy_cnt = 0;
            end else if (dm_gnt) begin
                exp_addr = dm_addr; exp_we = dm_we; exp_wdata = dm_wdata;
                gnt_log.push_back(1);
                issue_cnt = 0; busy_cnt = 0;
            end
            if (mem_req) begin
                issue_cnt++;
                check("mem_addr", {32'b0, mem_addr}, {32'b0, exp_addr});
                check("mem_we", {63'b0, mem_we}, {63'b0, exp_we});
                if (exp_we) check("mem_wdata", {32'b0, mem_wdata}, {32'b0, exp_wdata});
            end
            if (busy) busy_cnt++;
            if (if_rvalid || dm_rvalid) begin
                last_issue = issue_cnt;
                last_busy  = busy_cnt;
            end
            if (if_rvalid) begin
                if (if_q.size() == 0) check("if_rvalid_unexp", {63'b0, if_rvalid}, 64'd0);
                else begin
                    ei = if_q.pop_front();
                    check("if_rdata", {32'b0, if_rdata}, {32'b0, ei});
                end
            end else begin
                check("if_rdata_zero", {32'b0, if_rdata}, 64'd0);
            end
            if (dm_rvalid) begin
                if (dm_q.size() == 0) check("dm_rvalid_unexp", {63'b0, dm_rvalid}, 64'd0);
                else begin
                    e = dm_q.pop_front();
                    if (!e[32]) check("dm_rdata", {32'b0, dm_rdata}, {32'b0, e[31:0]});
                end
            end else begin
                check("dm_rdata_zero", {32'b0, dm_rdata}, 64'd0);
            end
        end
    end

    task automatic if_issue(input logic [31:0] a, output int waited);
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back(ref_rd(a));
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!if_gnt && waited < 200);
        check("if_gnt_seen", {63'b0, if_gnt}, 64'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic dm_issue(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, output int waited);
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
        dm_q.push_back({we, we ? 32'h0 : ref_rd(a)});
        if (we) ref_mem[a] = wd;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!dm_gnt && waited < 200);
        check("dm_gnt_seen", {63'b0, dm_gnt}, 64'd1);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || if_q.size() != 0 || dm_q.size() != 0) && n < 300);
        check("drain_busy", {63'b0, busy}, 64'd0);
        check("drain_queues", 64'(if_q.size() + dm_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int wa, wb;
        repeat (6) begin
            @(posedge clk);
            #1;
            if_req   = 1'($urandom_range(0, 1));
            if_addr  = $urandom;
            dm_req   = 1'($urandom_range(0, 1));
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            @(negedge clk);
            check("rst_ctl", {56'b0, if_gnt, if_rvalid, dm_gnt, dm_rvalid,
                              mem_req, mem_we, busy, spurious_rsp}, 64'd0);
            check("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
            check("rst_mem", {mem_addr, mem_wdata}, 64'd0);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        rst    = 1'b1;

        @(posedge clk);
        #1;
        if_issue(32'h0000_0010, wa);
        check("first_gnt_cycle", 64'(wa), 64'd1);
        wait_done();
        check("fetch_issue_cyc", 64'(last_issue), 64'd1);
        check("fetch_busy_cyc", 64'(last_busy), 64'd2);

        gnt_wait = 3;
        @(posedge clk);
        #1;
        dm_issue(1'b1, 32'h200, 32'h1234_5678, wa);
        wait_done();
        check("wr_hold_cyc", 64'(last_issue), 64'd4);
        gnt_wait = 0;
        @(posedge clk);
        #1;
        dm_issue(1'b0, 32'h200, 32'h0, wa);
        wait_done();

        ref_mem[32'h100] = 32'hDEAD_BEEF;
        mm_mem[32'h100]  = 32'hDEAD_BEEF;
        gnt_log.delete();
        @(posedge clk);
        #1;
        fork
            begin
                repeat (4) if_issue(32'h40, wa);
            end
            begin
                repeat (4) dm_issue(1'b0, 32'h100, 32'h0, wb);
            end
        join
        wait_done();
        check("ctn_len", 64'(gnt_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
            check("ctn_order", 64'(gnt_log[i]), 64'(i % 2));
        end

        rsp_wait = 9;
        @(posedge clk);
        #1;
        if_issue(32'h80, wa);
        if_issue(32'h84, wb);
        check("slow_busy_cyc", 64'(last_busy), 64'd11);
        check("slow_regrant", 64'(wb), 64'd12);
        wait_done();
        check("slow_busy_cyc2", 64'(last_busy), 64'd11);
        rsp_wait = 0;

        inj = 1'b1;
        @(negedge clk);
        check("spur_idle", {63'b0, spurious_rsp}, 64'd1);
        check("spur_no_rv", {62'b0, if_rvalid, dm_rvalid}, 64'd0);
        @(negedge clk);
        check("spur_pulse", {63'b0, spurious_rsp}, 64'd0);
        check("spur_state", {63'b0, busy}, 64'd0);

        rsp_wait = 50;
        @(posedge clk);
        #1;
        dm_issue(1'b0, 32'h300, 32'h0, wa);
        repeat (3) @(negedge clk);
        check("abort_pre_busy", {63'b0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_req", {63'b0, mem_req}, 64'd0);
        dm_q.delete();
        @(negedge clk);
        rst = 1'b1;
        rsp_wait = 0;
        repeat (3) @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        check("abort_spur", {63'b0, spurious_rsp}, 64'd1);
        check("abort_no_rv", {62'b0, if_rvalid, dm_rvalid}, 64'd0);
        check("abort_idle", {63'b0, busy}, 64'd0);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
